keypad_scan: RTL

Scans a 4x4 active-low matrix keypad and delivers debounced 4-bit key codes. It is the input-side counterpart to the board's multiplexed seven-segment display driver. It drives one keypad row low at a time, samples the four column lines, and debounces a press/release pair. It then emits one key code per press, in the same 4-bit nibble format the display driver consumes.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_tick_gen.sv | 31 +++
 rtl/keypad_scan.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    Scan,
    PressDb,
    Held,
    ReleaseDb
  } state_e;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'b1111;

  // Index of the lowest active-low column; only meaningful when some column is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    if (!cols[0]) begin
      return 2'd0;
    end else if (!cols[1]) begin
      return 2'd1;
    end else if (!cols[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan tick: one-cycle pulse every SCAN_DIV clocks.
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count 0..SCAN_DIV-1 and wrap.
  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned REPEAT_DLY   = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CNT);

  logic           tick;
  logic [3:0]     sync1_q, scol_q;
  state_e         state_q, state_d;
  logic [1:0]     row_idx_q, row_idx_d;
  logic [3:0]     code_q, code_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [DbW-1:0] db_inc;
  logic [3:0]     key_q, key_d;
  logic           key_valid_q, key_valid_d;
  logic           key_down_q, key_down_d;
  logic [3:0]     row_q;
  logic           cap_high;
  logic [3:0]     new_code;
  logic           accept;
  logic [3:0]     accept_code;

  keypad_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick_gen (
    .clk_i (clk),
    .clr_i (clr),
    .tick_o(tick)
  );

  assign cap_high = scol_q[code_q[1:0]];
  assign new_code = {row_idx_q, lowest_low(scol_q)};
  assign db_inc   = db_cnt_q + 1'b1;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDly  = RepW'(REPEAT_DLY);
  localparam logic [RepW-1:0] RepRate = RepW'(REPEAT_RATE);
  localparam logic [RepW-1:0] RepOne  = RepW'(1);

  // Counts down the ticks to the next auto-repeat; saturates at 1 during release debounce.
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DLY, REPEAT_RATE};
`endif

  // Next-state and output decode; everything advances only on scan ticks.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    code_d      = code_q;
    db_cnt_d    = db_cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    accept      = 1'b0;
    accept_code = code_q;

    if (tick) begin
      unique case (state_q)
        Scan: begin
          if (scol_q == COL_IDLE) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            code_d   = new_code;
            db_cnt_d = DbW'(1);
            if (DEBOUNCE_CNT == 1) begin
              accept      = 1'b1;
              accept_code = new_code;
            end else begin
              state_d = PressDb;
            end
          end
        end
        PressDb: begin
          if (!cap_high) begin
            db_cnt_d = db_inc;
            if (db_inc == DbMax) begin
              accept = 1'b1;
            end
          end else begin
            // Bounce: drop the candidate and move on to the next row.
            db_cnt_d  = '0;
            row_idx_d = row_idx_q + 2'd1;
            state_d   = Scan;
          end
        end
        Held: begin
          if (cap_high) begin
            db_cnt_d = DbW'(1);
            if (DEBOUNCE_CNT == 1) begin
              key_down_d = 1'b0;
              db_cnt_d   = '0;
              row_idx_d  = row_idx_q + 2'd1;
              state_d    = Scan;
            end else begin
              state_d = ReleaseDb;
            end
          end
        end
        ReleaseDb: begin
          if (cap_high) begin
            db_cnt_d = db_inc;
            if (db_inc == DbMax) begin
              key_down_d = 1'b0;
              db_cnt_d   = '0;
              row_idx_d  = row_idx_q + 2'd1;
              state_d    = Scan;
            end
          end else begin
            state_d = Held;
          end
        end
        default: state_d = Scan;
      endcase
    end

    if (accept) begin
      key_d       = accept_code;
      key_valid_d = 1'b1;
      key_down_d  = 1'b1;
      db_cnt_d    = '0;
      state_d     = Held;
    end

`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
    if (tick) begin
      if (accept) begin
        rep_cnt_d = RepDly;
      end else if (state_q == Held && !cap_high) begin
        if (rep_cnt_q <= RepOne) begin
          key_valid_d = 1'b1;
          rep_cnt_d   = RepRate;
        end else begin
          rep_cnt_d = rep_cnt_q - 1'b1;
        end
      end else if (state_q == Held || state_q == ReleaseDb) begin
        if (state_d == Scan) begin
          rep_cnt_d = '0;
        end else if (rep_cnt_q > RepOne) begin
          rep_cnt_d = rep_cnt_q - 1'b1;
        end
      end
    end
`endif
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q     <= COL_IDLE;
      scol_q      <= COL_IDLE;
      state_q     <= Scan;
      row_idx_q   <= 2'd0;
      code_q      <= 4'h0;
      db_cnt_q    <= '0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      row_q       <= ROW_RESET;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      sync1_q     <= col;
      scol_q      <= sync1_q;
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      code_q      <= code_d;
      db_cnt_q    <= db_cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      row_q       <= ~(4'b0001 << row_idx_d);
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign row       = row_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
